window3x3_gen: RTL
==================

# window3x3_gen

Generates 3x3 pixel windows from a raster 1-pixel/cycle stream with frame/line markers and presents them on the in3x3 window interface consumed by the 3x3 filter blocks (smoothing, edge, etc.). One window is emitted per accepted input pixel. The newest pixel is the window's bottom-right element, so the output is spatially shifted by (+1 row, +1 column). Missing border pixels are zero-filled or replicated, selected at compile time.

## Interface
- DATA_WIDTH, 8: pixel width in bits.
- LINE_AW, 11: line-buffer address width; MAX_LINE = 2**LINE_AW pixels per line.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- in_val  in  1  upstream has a valid pixel.
- in_rdy  out  1  block accepts the pixel.
- in_data  in  DATA_WIDTH  pixel.
- in_sof / in_sol / in_eol / in_eof  in  1 each  markers qualifying in_data.
- out3x3_val  out  1  window valid.
- out3x3_rdy  in  1  downstream accepts window.
- out3x3_data  out  9*DATA_WIDTH  window, p00 at [9*DW-1:8*DW] … p22 at [DW-1:0], row-major; row 0 = line r-2, column 0 = pixel c-2.
- out3x3_sof / out3x3_sol / out3x3_eol / out3x3_eof  out  1 each  markers of the pixel that produced the window.
- line_ovf  out  1  sticky: a line exceeded MAX_LINE pixels.

## Operation
- Accept: acc = in_val & in_rdy. in_rdy = out3x3_rdy | ~out3x3_val. No combinational path from in_val to out3x3_val.
- Position:
  - col_pos = in_sol ? 0 : col_cnt, where col_cnt is LINE_AW+1 bits and saturates at MAX_LINE.
  - row_pos = in_sof ? 0 : row_cnt, where row_cnt is 2 bits and saturates at 2.
- Counter update on acc:
  - col_cnt <= in_eol ? 0 : min(col_pos+1, MAX_LINE).
  - row_cnt <= in_sof ? 0 : row_cnt; then, if in_eol, saturating +1.
- Line buffers: two MAX_LINE x DATA_WIDTH, asynchronous read at col_pos.
  - lb1 holds line r-1; lb2 holds line r-2.
  - On acc with col_pos < MAX_LINE: lb2[col_pos] <= lb1[col_pos]; lb1[col_pos] <= in_data.
- Column history: win[row][1] and win[row][0] hold columns c-1 and c-2 for rows 0..2. On acc they shift, and the new column {lb2[col_pos], lb1[col_pos], in_data} enters.
- Missing pixels:
  - Row 0 is missing if row_pos < 2; row 1 is missing if row_pos < 1.
  - Column 0 is missing if col_pos < 2; column 1 is missing if col_pos < 1.
  - Row masking is applied first, then column masking.
- Overflow: a pixel with col_pos == MAX_LINE gives no RAM write and all-zero out3x3_data; markers are still forwarded. line_ovf is set and stays set until the next accepted in_sof. An accepted pixel that has both in_sof and overflow clears line_ovf.
- Output register, on acc: load data and markers, out3x3_val <= 1. Otherwise, if out3x3_rdy, out3x3_val <= 0.
- Markers pass through unchanged, one-for-one with pixels. No window is synthesized for flushing.
- Single-pixel lines (sol & eol on the same pixel) and sof & eol on the same pixel are legal.
- Reset: out3x3_val, out3x3_data, all out3x3 markers and line_ovf go to 0; col_cnt and row_cnt go to 0. Line buffers and win are not reset; their stale content is always masked by position.
- Reset mid-frame: the block behaves as if sof/sol was just seen.

## Timing
- Latency: window valid 1 cycle after the accepting edge.
- Throughput: 1 window/cycle with out3x3_rdy held high.
- Backpressure: while out3x3_val & ~out3x3_rdy, in_rdy = 0; out3x3_data and markers stay stable.
- Simultaneous pop and push is allowed: out3x3_val stays 1 and the new window loads.

## Configuration
- WINDOW_REPLICATE_EN undefined: missing pixels = 0.
- WINDOW_REPLICATE_EN defined:
  - A missing row copies the nearest present row below it: row 1 if present, else row 2.
  - A missing column copies the nearest present column to its right: column 1 if present, else column 2.

## Structure
- Package ir_filters_pkg holds:
  - DATA_WIDTH default.
  - Window slice-offset localparams P00_LSB…P22_LSB.
  - Border-mode encoding constants.
- Sub-module line_buffer_ram: single-port, asynchronous read, write-enable; instantiated twice (lb1, lb2).

## Test plan
- 4x4 frame, pixels 1..16, rdy=1, zero mode: pixel 6 (row 1, col 1) -> window {0,0,0, 0,1,2, 0,5,6}; pixel 16 -> {6,7,8, 10,11,12, 14,15,16}; 16 windows, markers aligned.
- Same frame with WINDOW_REPLICATE_EN: pixel 1 -> all nine = 1; pixel 6 -> {1,1,2, 1,1,2, 5,5,6}.
- Random out3x3_rdy toggling on a 640-pixel line: window sequence identical to the rdy=1 run; no drops or duplicates; data stable while stalled.
- LINE_AW=3 with a 10-pixel line: pixels 9 and 10 -> all-zero data, line_ovf=1; line_ovf cleared by the next sof.
- Reset asserted mid-line 2, then a new frame: first window has row 0/1 and column 0/1 masked; all outputs 0 in the cycle after reset.
- 1-pixel lines, 3 lines with values 7, 8, 9 (zero mode): third window = {0,0,7, 0,0,8, 0,0,9}.

Source files
------------

// File: rtl/ir_filters_pkg.sv
// ir_filters_pkg: constants shared by the 3x3 window generator and the
// filter blocks that consume its window interface.
//   DEFAULT_DATA_WIDTH  default pixel width in bits
//   P00_LSB..P22_LSB    pixel slot of each window element inside the
//                       packed window; bit offset = slot * DATA_WIDTH
//   border_mode_e       how pixels outside the image are filled
package ir_filters_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Row-major with p00 (oldest line, oldest column) in the top slot.
    localparam int P00_LSB = 8;
    localparam int P01_LSB = 7;
    localparam int P02_LSB = 6;
    localparam int P10_LSB = 5;
    localparam int P11_LSB = 4;
    localparam int P12_LSB = 3;
    localparam int P20_LSB = 2;
    localparam int P21_LSB = 1;
    localparam int P22_LSB = 0;

    typedef enum logic {
        BORDER_ZERO      = 1'b0,
        BORDER_REPLICATE = 1'b1
    } border_mode_e;

endpackage

// File: rtl/window3x3_gen_line_buffer_ram.sv
// line_buffer_ram: one line of pixel storage for the window generator.
// Single port, asynchronous read, synchronous write.
//   clk      clock
//   i_we     write enable
//   i_addr   read/write address (pixel column)
//   i_wdata  write data
//   o_rdata  combinational read data at i_addr (pre-write content)
module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 11
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window3x3_gen.sv
// window3x3_gen: turns a 1-pixel/cycle raster stream into 3x3 windows,
// one window per accepted pixel; the newest pixel is p22, so the window
// centre lags the input by one row and one column.
//   clk, rst_n            clock, synchronous active-low reset
//   in_val/in_rdy         input handshake
//   in_data, in_sof/sol/eol/eof   pixel and its markers
//   out3x3_val/out3x3_rdy output handshake
//   out3x3_data           9 pixels, p00 in the top slice ... p22 in the bottom
//   out3x3_sof/sol/eol/eof markers of the pixel that produced the window
//   line_ovf              sticky: a line exceeded 2**LINE_AW pixels
// Build option: define WINDOW_REPLICATE_EN to replicate border pixels
// instead of filling them with zero.
module window3x3_gen
    import ir_filters_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LINE_AW    = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_sof,
    input  logic                    in_sol,
    input  logic                    in_eol,
    input  logic                    in_eof,
    output logic                    out3x3_val,
    input  logic                    out3x3_rdy,
    output logic [9*DATA_WIDTH-1:0] out3x3_data,
    output logic                    out3x3_sof,
    output logic                    out3x3_sol,
    output logic                    out3x3_eol,
    output logic                    out3x3_eof,
    output logic                    line_ovf
);

    localparam int CNT_W = LINE_AW + 1;
    localparam logic [CNT_W-1:0] MAX_POS = {1'b1, {LINE_AW{1'b0}}};

`ifdef WINDOW_REPLICATE_EN
    localparam border_mode_e BORDER_MODE = BORDER_REPLICATE;
`else
    localparam border_mode_e BORDER_MODE = BORDER_ZERO;
`endif
    localparam bit REP = (BORDER_MODE == BORDER_REPLICATE);

    logic                    w_acc, w_ovf;
    logic                    w_row0_miss, w_row1_miss, w_col0_miss, w_col1_miss;
    logic [CNT_W-1:0]        r_col_cnt, w_col_pos, w_col_nxt;
    logic [1:0]              r_row_cnt, w_row_pos, w_row_nxt;
    logic [DATA_WIDTH-1:0]   w_lb1_q, w_lb2_q;
    logic [DATA_WIDTH-1:0]   r_win [3][2];
    logic [DATA_WIDTH-1:0]   w_new [3];
    logic [DATA_WIDTH-1:0]   w_rm  [3][3];
    logic [DATA_WIDTH-1:0]   w_cm  [3][3];
    logic [9*DATA_WIDTH-1:0] w_pack;

    // Ready depends only on the output register, never on in_val.
    assign in_rdy = out3x3_rdy | ~out3x3_val;
    assign w_acc  = in_val & in_rdy;

    assign w_col_pos = in_sol ? '0 : r_col_cnt;
    assign w_row_pos = in_sof ? '0 : r_row_cnt;
    assign w_ovf     = (w_col_pos == MAX_POS);
    assign w_col_nxt = in_eol ? '0 : (w_ovf ? MAX_POS : w_col_pos + 1'b1);

    always_comb begin
        w_row_nxt = w_row_pos;
        if (in_eol && w_row_pos != 2'd2) w_row_nxt = w_row_pos + 2'd1;
    end

    // lb1 holds line r-1, lb2 line r-2; the line moving out of lb1 is
    // what lb2 gets, so both share one address per cycle.
    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(LINE_AW)) u_lb1 (
        .clk     (clk),
        .i_we    (w_acc & ~w_ovf),
        .i_addr  (w_col_pos[LINE_AW-1:0]),
        .i_wdata (in_data),
        .o_rdata (w_lb1_q)
    );

    line_buffer_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(LINE_AW)) u_lb2 (
        .clk     (clk),
        .i_we    (w_acc & ~w_ovf),
        .i_addr  (w_col_pos[LINE_AW-1:0]),
        .i_wdata (w_lb1_q),
        .o_rdata (w_lb2_q)
    );

    assign w_new[0] = w_lb2_q;
    assign w_new[1] = w_lb1_q;
    assign w_new[2] = in_data;

    assign w_row0_miss = (w_row_pos != 2'd2);
    assign w_row1_miss = (w_row_pos == 2'd0);
    assign w_col0_miss = (w_col_pos[CNT_W-1:1] == '0);
    assign w_col1_miss = (w_col_pos == '0);

    // Rows first, then columns, so a corner pixel picks up the value that
    // row replication already moved into its row.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_rm[r][0] = r_win[r][0];
            w_rm[r][1] = r_win[r][1];
            w_rm[r][2] = w_new[r];
        end
        for (int c = 0; c < 3; c++) begin
            if (w_row1_miss) w_rm[1][c] = REP ? w_rm[2][c] : '0;
            if (w_row0_miss) w_rm[0][c] = REP ? w_rm[1][c] : '0;
        end
        for (int r = 0; r < 3; r++) begin
            w_cm[r][0] = w_rm[r][0];
            w_cm[r][1] = w_rm[r][1];
            w_cm[r][2] = w_rm[r][2];
            if (w_col1_miss) w_cm[r][1] = REP ? w_cm[r][2] : '0;
            if (w_col0_miss) w_cm[r][0] = REP ? w_cm[r][1] : '0;
        end
    end

    // Overflowing pixels produce an all-zero window.
    always_comb begin
        w_pack = '0;
        if (!w_ovf) begin
            w_pack[P00_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[0][0];
            w_pack[P01_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[0][1];
            w_pack[P02_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[0][2];
            w_pack[P10_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[1][0];
            w_pack[P11_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[1][1];
            w_pack[P12_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[1][2];
            w_pack[P20_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[2][0];
            w_pack[P21_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[2][1];
            w_pack[P22_LSB*DATA_WIDTH +: DATA_WIDTH] = w_cm[2][2];
        end
    end

    // Column history carries no reset: stale columns are always masked.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_new[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            out3x3_val  <= 1'b0;
            out3x3_data <= '0;
            out3x3_sof  <= 1'b0;
            out3x3_sol  <= 1'b0;
            out3x3_eol  <= 1'b0;
            out3x3_eof  <= 1'b0;
            line_ovf    <= 1'b0;
        end else if (w_acc) begin
            r_col_cnt   <= w_col_nxt;
            r_row_cnt   <= w_row_nxt;
            out3x3_val  <= 1'b1;
            out3x3_data <= w_pack;
            out3x3_sof  <= in_sof;
            out3x3_sol  <= in_sol;
            out3x3_eol  <= in_eol;
            out3x3_eof  <= in_eof;
            // A new frame wins over an overflow on the same pixel.
            if (in_sof)     line_ovf <= 1'b0;
            else if (w_ovf) line_ovf <= 1'b1;
        end else if (out3x3_rdy) begin
            out3x3_val <= 1'b0;
        end
    end

endmodule
